// File: rtl/punc_debug_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : punc_debug_scanner
//  Purpose  : Walks the PUnC debug ports on a start pulse and emits a snapshot
//             stream (PC, every register-file entry, then a window of memory
//             words) on a valid/ready port. Holds the core while scanning.
//  Revision : 1.0 - initial release
// ============================================================================
module punc_debug_scanner #(
    parameter int RF_WORDS = 8,
    parameter int AW       = 16,
    parameter int DW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] mem_base,
    input  logic [15:0]   mem_count,
    output logic [AW-1:0] mem_debug_addr,
    output logic [2:0]    rf_debug_addr,
    input  logic [DW-1:0] mem_debug_data,
    input  logic [DW-1:0] rf_debug_data,
    input  logic [DW-1:0] pc_debug_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_tag,
    output logic [15:0]   out_idx,
    output logic          out_last,
    output logic          busy,
    output logic          core_hold,
    output logic          done
);

    // Controller states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CAP  = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;
    localparam logic [1:0] c_ST_FIN  = 2'd3;

    // Snapshot phases; encoding doubles as the stream tag
    localparam logic [1:0] c_PH_PC  = 2'd0;
    localparam logic [1:0] c_PH_RF  = 2'd1;
    localparam logic [1:0] c_PH_MEM = 2'd2;

    localparam logic [2:0] c_RF_LAST = 3'(RF_WORDS - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [1:0]    r_phase;
    logic [2:0]    r_rf_addr;
    logic [AW-1:0] r_mem_addr;
    logic [15:0]   r_remaining;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic [1:0]    r_out_tag;
    logic [15:0]   r_out_idx;
    logic          r_out_last;

    logic          w_hs;
    logic          w_rf_last;
    logic          w_seq_end;
    logic [DW-1:0] w_sel_data;
    logic [15:0]   w_sel_idx;

    assign w_hs      = (r_state == c_ST_HOLD) && r_out_valid && out_ready;
    assign w_rf_last = (r_rf_addr == c_RF_LAST);

    // The current word is the final one of the snapshot
    assign w_seq_end = ((r_phase == c_PH_RF)  && w_rf_last && (r_remaining == 16'd0)) ||
                       ((r_phase == c_PH_MEM) && (r_remaining == 16'd1));

    // Data and index of the word selected by the current phase
    always_comb begin
        w_sel_data = pc_debug_data;
        w_sel_idx  = 16'd0;
        case (r_phase)
            c_PH_RF: begin
                w_sel_data = rf_debug_data;
                w_sel_idx  = {13'd0, r_rf_addr};
            end
            c_PH_MEM: begin
                w_sel_data = mem_debug_data;
                w_sel_idx  = 16'(r_mem_addr);
            end
            default: begin
                w_sel_data = pc_debug_data;
                w_sel_idx  = 16'd0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_nxt = c_ST_CAP;
            c_ST_CAP:  w_state_nxt = c_ST_HOLD;
            c_ST_HOLD: if (w_hs) w_state_nxt = w_seq_end ? c_ST_FIN : c_ST_CAP;
            c_ST_FIN:  w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy      = (r_state != c_ST_IDLE);
        core_hold = (r_state != c_ST_IDLE);
        done      = (r_state == c_ST_FIN);
    end

    // Sequence pointers and registered stream word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase     <= c_PH_PC;
            r_rf_addr   <= 3'd0;
            r_mem_addr  <= '0;
            r_remaining <= 16'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= 2'd0;
            r_out_idx   <= 16'd0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_phase     <= c_PH_PC;
                        r_rf_addr   <= 3'd0;
                        r_mem_addr  <= mem_base;
                        r_remaining <= mem_count;
                    end
                end
                c_ST_CAP: begin
                    r_out_data  <= w_sel_data;
                    r_out_tag   <= r_phase;
                    r_out_idx   <= w_sel_idx;
                    r_out_last  <= w_seq_end;
                    r_out_valid <= 1'b1;
                end
                c_ST_HOLD: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        case (r_phase)
                            c_PH_PC: r_phase <= c_PH_RF;
                            c_PH_RF: begin
                                if (!w_rf_last)                r_rf_addr <= r_rf_addr + 3'd1;
                                else if (r_remaining != 16'd0) r_phase   <= c_PH_MEM;
                            end
                            c_PH_MEM: begin
                                // Address wraps naturally at the top of the space
                                r_mem_addr  <= r_mem_addr + AW'(1);
                                r_remaining <= r_remaining - 16'd1;
                            end
                            default: r_phase <= c_PH_PC;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_debug_addr = r_mem_addr;
    assign rf_debug_addr  = r_rf_addr;
    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_tag        = r_out_tag;
    assign out_idx        = r_out_idx;
    assign out_last       = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_punc_debug_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_punc_debug_scanner
//  Purpose  : Self-checking bench for punc_debug_scanner. A list of expected
//             snapshot words is built from the core contents, and the stream
//             is checked word by word under varied ready patterns.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_punc_debug_scanner;

    localparam int RF_WORDS = 8;
    localparam int AW       = 16;
    localparam int DW       = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] mem_base;
    logic [15:0]   mem_count;
    logic [AW-1:0] mem_debug_addr;
    logic [2:0]    rf_debug_addr;
    logic [DW-1:0] mem_debug_data;
    logic [DW-1:0] rf_debug_data;
    logic [DW-1:0] pc_debug_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_tag;
    logic [15:0]   out_idx;
    logic          out_last;
    logic          busy;
    logic          core_hold;
    logic          done;

    // Core model: register file array and memory computed from the address
    logic [DW-1:0] rf_vals [RF_WORDS];
    logic [DW-1:0] mem_key;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0]    tag;
        logic [15:0]   idx;
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    word_t exp_q[$];

    always #5 clk = ~clk;

    assign mem_debug_data = mem_debug_addr ^ mem_key;
    assign rf_debug_data  = rf_vals[rf_debug_addr];

    punc_debug_scanner #(.RF_WORDS(RF_WORDS), .AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mem_base       (mem_base),
        .mem_count      (mem_count),
        .mem_debug_addr (mem_debug_addr),
        .rf_debug_addr  (rf_debug_addr),
        .mem_debug_data (mem_debug_data),
        .rf_debug_data  (rf_debug_data),
        .pc_debug_data  (pc_debug_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_tag        (out_tag),
        .out_idx        (out_idx),
        .out_last       (out_last),
        .busy           (busy),
        .core_hold      (core_hold),
        .done           (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Snapshot content from the core state: PC, RF[0..N-1], MEM[base .. base+count-1]
    task automatic build_expected(input logic [15:0] base, input logic [15:0] count);
        logic [15:0] a;
        exp_q.delete();
        exp_q.push_back('{2'd0, 16'd0, pc_debug_data, 1'b0});
        for (int i = 0; i < RF_WORDS; i++)
            exp_q.push_back('{2'd1, 16'(i), rf_vals[i], (i == RF_WORDS - 1) && (count == 16'd0)});
        for (int j = 0; j < int'(count); j++) begin
            a = base + 16'(j);
            exp_q.push_back('{2'd2, a, a ^ mem_key, j == int'(count) - 1});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_hold"}, core_hold, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_tag"}, out_tag, 0);
        check({tag, "_idx"}, out_idx, 0);
        check({tag, "_maddr"}, mem_debug_addr, 0);
        check({tag, "_raddr"}, rf_debug_addr, 0);
    endtask

    // rdy_mode 0: ready high, 1: random ready. stall_word/abort_word/busy_start_cyc < 0 disable.
    task automatic run_scan(input logic [15:0] base, input logic [15:0] count, input int rdy_mode,
                            input int stall_word, input int stall_len, input int abort_word,
                            input int busy_start_cyc, input bit start_at_done);
        int    k = 0;
        int    cyc = 0;
        int    budget;
        int    stall_left;
        int    last_hs_cyc = -1;
        int    expect_v = 0;   // 0 don't care, 1 expect valid held, 2 expect valid low
        bit    finished = 0;
        bit    hs;
        build_expected(base, count);
        budget     = 100 + 6 * exp_q.size() + stall_len;
        stall_left = stall_len;
        @(negedge clk);
        mem_base  = base;
        mem_count = count;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        mem_base  = 16'($urandom);
        mem_count = 16'($urandom);
        while (!finished && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (start) start = 1'b0;
            check("busy", busy, 1);
            check("core_hold", core_hold, 1);
            check("done", done, (last_hs_cyc >= 0) && (cyc == last_hs_cyc + 1));
            if (cyc == 1) check("lat_cyc1_valid", out_valid, 0);
            if (cyc == 2) check("lat_cyc2_valid", out_valid, 1);
            if (expect_v == 1) check("stall_valid_held", out_valid, 1);
            if (expect_v == 2) check("no_back_to_back", out_valid, 0);
            if (last_hs_cyc >= 0 && cyc == last_hs_cyc + 1) begin
                finished = 1;
                if (start_at_done) start = 1'b1;
            end else begin
                if (out_valid) begin
                    if (k < exp_q.size()) begin
                        check("word_tag", out_tag, exp_q[k].tag);
                        check("word_idx", out_idx, exp_q[k].idx);
                        check("word_data", out_data, exp_q[k].data);
                        check("word_last", out_last, exp_q[k].last);
                    end else begin
                        check("extra_word", k, exp_q.size() - 1);
                    end
                end
                if (abort_word >= 0 && k == abort_word && out_valid) begin
                    rst = 1'b1;
                    #1;
                    check_reset_outputs("abort");
                    @(negedge clk);
                    rst = 1'b0;
                    out_ready = 1'b0;
                    repeat (4) begin
                        @(negedge clk);
                        check("abort_no_done", done, 0);
                        check("abort_idle", busy, 0);
                    end
                    return;
                end
                if (busy_start_cyc >= 0 && cyc == busy_start_cyc) begin
                    start     = 1'b1;
                    mem_base  = 16'($urandom);
                    mem_count = 16'($urandom_range(1, 30));
                end
                if (out_valid && k == stall_word && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else if (rdy_mode == 1) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    out_ready = 1'b1;
                end
                hs = out_valid && out_ready;
                if (hs) begin
                    if (k == exp_q.size() - 1) last_hs_cyc = cyc;
                    k++;
                    expect_v = 2;
                end else begin
                    expect_v = out_valid ? 1 : 0;
                end
            end
        end
        if (!finished) check("timeout", 0, 1);
        check("word_count", k, exp_q.size());
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        check("post_busy", busy, 0);
        check("post_hold", core_hold, 0);
        check("post_done", done, 0);
        check("post_valid", out_valid, 0);
        @(negedge clk);
        check("post_idle", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        mem_base  = '0;
        mem_count = '0;
        mem_key   = '0;
        pc_debug_data = '0;
        for (int i = 0; i < RF_WORDS; i++) rf_vals[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed core contents
        pc_debug_data = 16'h3004;
        for (int i = 0; i < RF_WORDS; i++) rf_vals[i] = 16'h0010 + 16'(i);
        mem_key = 16'h0000;

        run_scan(16'h3000, 16'd4, 0, -1, 0, -1, -1, 0);   // basic 13 words
        run_scan(16'h3000, 16'd4, 0,  3, 5, -1, -1, 0);   // stall on word 3
        run_scan(16'h3000, 16'd0, 0, -1, 0, -1, -1, 0);   // no memory words
        run_scan(16'hFFFE, 16'd3, 0, -1, 0, -1, -1, 0);   // address wrap
        run_scan(16'h3000, 16'd4, 0, -1, 0,  4, -1, 0);   // reset on 5th word
        run_scan(16'h3000, 16'd4, 0, -1, 0, -1, -1, 0);   // full snapshot after abort
        run_scan(16'h3000, 16'd4, 1, -1, 0, -1,  5, 1);   // start while busy / at done

        // Randomized core contents, windows and ready patterns
        for (int r = 0; r < 10; r++) begin
            pc_debug_data = 16'($urandom);
            mem_key       = 16'($urandom);
            for (int i = 0; i < RF_WORDS; i++) rf_vals[i] = 16'($urandom);
            run_scan(16'($urandom), 16'($urandom_range(0, 20)), 1,
                     int'($urandom_range(0, 12)), int'($urandom_range(0, 6)), -1,
                     (r % 3 == 0) ? 7 : -1, (r % 2) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
